snax_simbacore_csr_manager: RTL and testbench

- Core-facing CSR front end that drives the SimbaCore accelerator's config handshake (initiator side of csr_reg_set valid/ready).
- Holds double-buffered RW config registers.
- Launches a config transaction on a start-CSR write.
- Returns reads of RW shadows and of the accelerator's RO status registers.
- Sits between the Snitch core CSR request port and the SimbaCore shell wrapper.

---
 rtl/snax_simbacore_csr_pkg.sv | 31 +++
 rtl/snax_simbacore_csr_rsp_slot.sv | 27 ++
 rtl/snax_simbacore_csr_manager.sv | 126 ++++++++++++
 tb/tb_snax_simbacore_csr_manager.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/snax_simbacore_csr_pkg.sv
// Shared types and default address map for the SimbaCore CSR manager.
package snax_simbacore_csr_pkg;

  localparam int unsigned DefRWCount   = 7;
  localparam int unsigned DefROCount   = 4;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 32;

  typedef enum logic {
    IDLE,
    LAUNCH
  } csr_state_e;

  // Word offsets for the default configuration; the manager re-derives them from its parameters.
  typedef enum int unsigned {
    CfgBase   = 0,
    StartAddr = DefRWCount - 1,
    RoBase    = DefRWCount,
    PerfBase  = DefRWCount + DefROCount
  } csr_addr_e;

  typedef enum int unsigned {
    RegMode   = 0,
    RegSeqLen = 1,
    RegDModel = 2,
    RegDtRank = 3,
    RegDInner = 4,
    RegDFinal = 5
  } cfg_reg_e;

endpackage

// File: rtl/snax_simbacore_csr_rsp_slot.sv
// Single-entry valid/ready holding register for CSR read responses.
module snax_simbacore_csr_rsp_slot #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push,
  input  logic [DataWidth-1:0] push_data,
  output logic                 valid,
  output logic [DataWidth-1:0] data,
  input  logic                 ready
);

  // The owner only pushes when the slot is empty or draining this cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      data  <= push_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/snax_simbacore_csr_manager.sv
// Core-facing CSR front end for SimbaCore: double-buffered config shadows and launch handshake.
// Optional perf counters (launches, launch stall cycles) with SNAX_SIMBACORE_CSR_PERF_EN.
module snax_simbacore_csr_manager
  import snax_simbacore_csr_pkg::*;
#(
  parameter int unsigned RegRWCount   = DefRWCount,
  parameter int unsigned RegROCount   = DefROCount,
  parameter int unsigned RegDataWidth = DefDataWidth,
  parameter int unsigned RegAddrWidth = DefAddrWidth
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [RegAddrWidth-1:0]                 csr_req_addr_i,
  input  logic [RegDataWidth-1:0]                 csr_req_data_i,
  input  logic                                    csr_req_write_i,
  input  logic                                    csr_req_valid_i,
  output logic                                    csr_req_ready_o,
  output logic [RegDataWidth-1:0]                 csr_rsp_data_o,
  output logic                                    csr_rsp_valid_o,
  input  logic                                    csr_rsp_ready_i,
  output logic [RegRWCount-1:0][RegDataWidth-1:0] csr_reg_set_o,
  output logic                                    csr_reg_set_valid_o,
  input  logic                                    csr_reg_set_ready_i,
  input  logic [RegROCount-1:0][RegDataWidth-1:0] csr_reg_ro_set_i
);

  localparam logic [RegAddrWidth-1:0] StartA = RegAddrWidth'(RegRWCount - 1);
  localparam logic [RegAddrWidth-1:0] RoA    = RegAddrWidth'(RegRWCount);
  localparam logic [RegAddrWidth-1:0] PerfA  = RegAddrWidth'(RegRWCount + RegROCount);

  csr_state_e state_q, state_d;
  logic [RegRWCount-2:0][RegDataWidth-1:0] shadow_q;
  logic [RegRWCount-1:0][RegDataWidth-1:0] launch_q;
  logic [RegDataWidth-1:0] rd_data;
  logic is_start, start_wr, accept, launch_go, handshake;

  assign is_start  = (csr_req_addr_i == StartA);
  assign start_wr  = csr_req_write_i && is_start;
  assign handshake = csr_reg_set_valid_o && csr_reg_set_ready_i;

  // A start during LAUNCH waits, so the launched set never changes under valid.
  assign csr_req_ready_o = !(csr_rsp_valid_o && !csr_rsp_ready_i) &&
                           !(start_wr && (state_q == LAUNCH));
  assign accept          = csr_req_valid_i && csr_req_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    launch_go = 1'b0;
    case (state_q)
      IDLE: if (accept && start_wr && csr_req_data_i[0]) begin
        state_d   = LAUNCH;
        launch_go = 1'b1;
      end
      LAUNCH: if (csr_reg_set_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      launch_q <= '0;
    end else begin
      for (int i = 0; i < int'(RegRWCount) - 1; i++)
        if (accept && csr_req_write_i && csr_req_addr_i == RegAddrWidth'(i))
          shadow_q[i] <= csr_req_data_i;
      if (launch_go) begin
        for (int i = 0; i < int'(RegRWCount) - 1; i++) launch_q[i] <= shadow_q[i];
        launch_q[RegRWCount-1] <= csr_req_data_i;
      end
    end
  end

  assign csr_reg_set_o       = launch_q;
  assign csr_reg_set_valid_o = (state_q == LAUNCH);

`ifdef SNAX_SIMBACORE_CSR_PERF_EN
  logic [31:0] launch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      launch_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (handshake) launch_cnt_q <= launch_cnt_q + 32'd1;
      if (csr_reg_set_valid_o && !csr_reg_set_ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(RegRWCount) - 1; i++)
      if (csr_req_addr_i == RegAddrWidth'(i)) rd_data = shadow_q[i];
    if (is_start) rd_data = launch_q[RegRWCount-1];
    for (int i = 0; i < int'(RegROCount); i++)
      if (csr_req_addr_i == RoA + RegAddrWidth'(i)) rd_data = csr_reg_ro_set_i[i];
`ifdef SNAX_SIMBACORE_CSR_PERF_EN
    if (csr_req_addr_i == PerfA)                   rd_data = RegDataWidth'(launch_cnt_q);
    if (csr_req_addr_i == PerfA + RegAddrWidth'(1)) rd_data = RegDataWidth'(stall_cnt_q);
`else
    if (csr_req_addr_i == PerfA) rd_data = '0;
`endif
  end

  snax_simbacore_csr_rsp_slot #(
    .DataWidth(RegDataWidth)
  ) i_rsp_slot (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (accept && !csr_req_write_i),
    .push_data(rd_data),
    .valid    (csr_rsp_valid_o),
    .data     (csr_rsp_data_o),
    .ready    (csr_rsp_ready_i)
  );

endmodule

// File: tb/tb_snax_simbacore_csr_manager.sv
// Directed bench for snax_simbacore_csr_manager: vector table plus launch/backpressure/reset sequences.
module tb_snax_simbacore_csr_manager;

  localparam int RW = 7, RO = 4, DW = 32, AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic req_write = 1'b0, req_valid = 1'b0, req_ready;
  logic [DW-1:0] rsp_data;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [RW-1:0][DW-1:0] reg_set;
  logic set_valid, set_ready = 1'b0;
  logic [RO-1:0][DW-1:0] ro_set;

  always #5 clk = ~clk;

  snax_simbacore_csr_manager dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .csr_req_addr_i     (req_addr),
    .csr_req_data_i     (req_data),
    .csr_req_write_i    (req_write),
    .csr_req_valid_i    (req_valid),
    .csr_req_ready_o    (req_ready),
    .csr_rsp_data_o     (rsp_data),
    .csr_rsp_valid_o    (rsp_valid),
    .csr_rsp_ready_i    (rsp_ready),
    .csr_reg_set_o      (reg_set),
    .csr_reg_set_valid_o(set_valid),
    .csr_reg_set_ready_i(set_ready),
    .csr_reg_ro_set_i   (ro_set)
  );

  int nvec = 0, nerr = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [RW*DW-1:0] act, input logic [RW*DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    #1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #2; n++;
    end
    if (n == 50) begin
      nvec++; nerr++;
      $display("FAIL req_timeout: addr %0d never accepted", a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    req(1'b0, a, '0);
    check({name, "_vld"}, rsp_valid, 1);
    check(name, rsp_data, exp);
  endtask

  initial begin
    vec_t tbl[22];
    logic [RW-1:0][DW-1:0] e, e2;
    logic [31:0] exp_l, exp_s;

    ro_set[0] = 32'h11; ro_set[1] = 32'h1234; ro_set[2] = 32'h22; ro_set[3] = 32'h33;
    for (int i = 0; i < 6; i++) tbl[i] = '{1'b1, i, i + 1, 0};
    for (int i = 0; i < 6; i++) tbl[6 + i] = '{1'b0, i, 0, i + 1};
    tbl[12] = '{1'b0, 6, 0, 0};
    tbl[13] = '{1'b0, 8, 0, 32'h1234};
    tbl[14] = '{1'b0, 100, 0, 0};
    tbl[15] = '{1'b1, 8, 32'hDEAD, 0};
    tbl[16] = '{1'b0, 8, 0, 32'h1234};
    tbl[17] = '{1'b1, 100, 5, 0};
    tbl[18] = '{1'b0, 7, 0, 32'h11};
    tbl[19] = '{1'b0, 10, 0, 32'h33};
    tbl[20] = '{1'b1, 6, 0, 0};
    tbl[21] = '{1'b0, 32'hFFFF_FFFF, 0, 0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_set_valid", set_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_reg_set", reg_set, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      if (tbl[i].wr) req(1'b1, tbl[i].addr, tbl[i].data);
      else rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
    end
    check("start0_no_launch", set_valid, 0);
    rd(11, 0, "perf_pre");

    // single launch, accelerator ready
    for (int i = 0; i < 6; i++) e[i] = i + 1;
    e[6] = 1;
    set_ready = 1'b1;
    req(1'b1, 6, 1);
    check("l1_valid", set_valid, 1);
    check("l1_set", reg_set, e);
    @(posedge clk); #1;
    check("l1_valid_drop", set_valid, 0);
    rd(6, 1, "start_rb");

    // stalled launch; shadow update and second start during the stall
    set_ready = 1'b0;
    req(1'b1, 6, 1);
    req(1'b1, 2, 32'hAA);
    check("l2_valid", set_valid, 1);
    check("l2_set_stable", reg_set, e);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6; req_data = 1;
    #1;
    check("l2_start_stall", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("l2_stall_ready", req_ready, 0);
      check("l2_stall_valid", set_valid, 1);
    end
    set_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    check("l2_hs_idle", set_valid, 0);
    check("l2_start_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    e2 = e; e2[2] = 32'hAA;
    check("l3_valid", set_valid, 1);
    check("l3_set", reg_set, e2);
    @(posedge clk); #1;
    check("l3_valid_drop", set_valid, 0);

    // response backpressure
    rsp_ready = 1'b0;
    req(1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 1);
      @(posedge clk); #1;
    end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 1;
    #1;
    check("bp_req_stall", req_ready, 0);
    check("bp_data_hold", rsp_data, 1);
    rsp_ready = 1'b1;
    #1;
    check("bp_req_go", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp2_valid", rsp_valid, 1);
    check("bp2_data", rsp_data, 2);
    @(posedge clk); #1;
    check("bp2_drain", rsp_valid, 0);

    // reset during LAUNCH
    set_ready = 1'b0;
    req(1'b1, 6, 1);
    check("rl_valid", set_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rl_valid_drop", set_valid, 0);
    check("rl_set_clear", reg_set, 0);
    for (int a = 0; a < 7; a++) rd(a, 0, $sformatf("rl_rb%0d", a));

    // three launches, one stalled four cycles
    set_ready = 1'b1;
    req(1'b1, 6, 1);
    @(posedge clk); #1;
    req(1'b1, 6, 1);
    @(posedge clk); #1;
    set_ready = 1'b0;
    req(1'b1, 6, 1);
    repeat (4) @(posedge clk);
    #1;
    set_ready = 1'b1;
    @(posedge clk); #1;
    check("pf_done", set_valid, 0);
`ifdef SNAX_SIMBACORE_CSR_PERF_EN
    exp_l = 3; exp_s = 4;
`else
    exp_l = 0; exp_s = 0;
`endif
    rd(11, exp_l, "perf_launch");
    rd(12, exp_s, "perf_stall");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

endmodule
